// File: rtl/shift_reg_pkg.sv
// Definitions shared by the serial/parallel converters (SIPO and PISO):
// FSM encoding, bit-counter sizing and PISO defaults.
package shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A counter that must hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int PISO_WIDTH_DEFAULT = 4;
    localparam bit PISO_LSB_FIRST     = 1'b1;

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in shift register. New bits enter at index 1, so the
// first bit of a word ends up at index WIDTH once the word is complete.
module sipo_shift_core
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             sin,
    output logic [1:WIDTH]   word_next
);

    logic [1:WIDTH] q;

    // restart wins over en: a frame bit always begins a clean word
    always_comb begin
        word_next = q;
        if (restart) begin
            word_next = {sin, {(WIDTH - 1){1'b0}}};
        end else if (en) begin
            word_next = {sin, q[1:WIDTH-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= word_next;
        end
    end

endmodule

// File: rtl/shift_reg_sipo.sv
// Serial-in parallel-out converter: framed bit capture, word assembly and a
// single-entry valid/ready output register with a sticky overrun flag.
module shift_reg_sipo
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sin,
    input  logic           sin_en,
    input  logic           frame,
    output logic [1:WIDTH] y,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           busy,
    output logic           overrun
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [CW-1:0]   count;
    logic            start;
    logic            shift;
    logic            complete;
    logic [1:WIDTH]  word_next;

    assign start    = sin_en & frame;
    assign shift    = (state == SHIFT) & sin_en & ~frame;
    assign complete = shift & (count == LAST);
    assign busy     = (state == SHIFT);

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (shift),
        .restart   (start),
        .sin       (sin),
        .word_next (word_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (start) begin
                state <= SHIFT;
                count <= CW'(1);
            end else if (shift) begin
                if (complete) begin
                    state <= IDLE;
                    count <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end

            // A finished word may enter y only if y is empty or being consumed now
            if (complete) begin
                if (!y_valid || y_ready) begin
                    y       <= word_next;
                    y_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_sipo.sv
// Directed bench for shift_reg_sipo (WIDTH=4): vector table plus a few
// hand-written multi-cycle sequences.
module tb_shift_reg_sipo;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b0;
    logic         sin_en = 1'b0;
    logic         frame = 1'b0;
    logic         y_ready = 1'b0;
    logic [1:W]   y;
    logic         y_valid;
    logic         busy;
    logic         overrun;

    int total  = 0;
    int passed = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       sin_en;
        logic       frame;
        logic       sin;
        logic       rdy;
        logic [1:W] ey;
        logic       ev;
        logic       eb;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    shift_reg_sipo #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .sin     (sin),
        .sin_en  (sin_en),
        .frame   (frame),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input string n, input logic r, input logic en, input logic fr,
                       input logic s, input logic rd, input logic [1:W] ey,
                       input logic ev, input logic eb, input logic eo);
        vec_t v;
        v.name = n; v.rst = r; v.sin_en = en; v.frame = fr; v.sin = s; v.rdy = rd;
        v.ey = ey; v.ev = ev; v.eb = eb; v.eo = eo;
        vecs.push_back(v);
    endtask

    // Drive one cycle, then check all outputs just after the edge.
    task automatic cycle(input logic r, input logic en, input logic fr, input logic s,
                         input logic rd);
        rst = r; sin_en = en; frame = fr; sin = s; y_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string n, input logic [1:W] ey, input logic ev,
                             input logic eb, input logic eo);
        chk({n, ".y"}, 32'(y), 32'(ey));
        chk({n, ".y_valid"}, 32'(y_valid), 32'(ev));
        chk({n, ".busy"}, 32'(busy), 32'(eb));
        chk({n, ".overrun"}, 32'(overrun), 32'(eo));
    endtask

    initial begin
        logic [W-1:0] x;
        logic [1:W]   ex;

        //   name      rst en fr s rdy  y        v  b  o
        add("reset",    1, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        add("idle_ign", 0, 1, 0, 1, 1, 4'b0000, 0, 0, 0);
        // bits 1,0,1,1 back to back
        add("a_b0",     0, 1, 1, 1, 1, 4'b0000, 0, 1, 0);
        add("a_b1",     0, 1, 0, 0, 1, 4'b0000, 0, 1, 0);
        add("a_b2",     0, 1, 0, 1, 1, 4'b0000, 0, 1, 0);
        add("a_b3",     0, 1, 0, 1, 1, 4'b1101, 1, 0, 0);
        add("a_hs",     0, 0, 0, 0, 1, 4'b1101, 0, 0, 0);
        // same bits with a 3-cycle gap
        add("g_rst",    1, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        add("g_b0",     0, 1, 1, 1, 1, 4'b0000, 0, 1, 0);
        add("g_gap1",   0, 0, 1, 0, 1, 4'b0000, 0, 1, 0);
        add("g_gap2",   0, 0, 0, 1, 1, 4'b0000, 0, 1, 0);
        add("g_gap3",   0, 0, 0, 0, 1, 4'b0000, 0, 1, 0);
        add("g_b1",     0, 1, 0, 0, 1, 4'b0000, 0, 1, 0);
        add("g_b2",     0, 1, 0, 1, 1, 4'b0000, 0, 1, 0);
        add("g_b3",     0, 1, 0, 1, 1, 4'b1101, 1, 0, 0);
        add("g_hs",     0, 0, 0, 0, 1, 4'b1101, 0, 0, 0);
        // restart after 2 bits, new word 0,0,0,1
        add("r_rst",    1, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        add("r_p0",     0, 1, 1, 1, 1, 4'b0000, 0, 1, 0);
        add("r_p1",     0, 1, 0, 0, 1, 4'b0000, 0, 1, 0);
        add("r_b0",     0, 1, 1, 0, 1, 4'b0000, 0, 1, 0);
        add("r_b1",     0, 1, 0, 0, 1, 4'b0000, 0, 1, 0);
        add("r_b2",     0, 1, 0, 0, 1, 4'b0000, 0, 1, 0);
        add("r_b3",     0, 1, 0, 1, 1, 4'b1000, 1, 0, 0);
        add("r_hs",     0, 0, 0, 0, 1, 4'b1000, 0, 0, 0);
        // back-to-back 1101 then 0110 with consumer stalled
        add("o_rst",    1, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        add("o_a0",     0, 1, 1, 1, 0, 4'b0000, 0, 1, 0);
        add("o_a1",     0, 1, 0, 0, 0, 4'b0000, 0, 1, 0);
        add("o_a2",     0, 1, 0, 1, 0, 4'b0000, 0, 1, 0);
        add("o_a3",     0, 1, 0, 1, 0, 4'b1101, 1, 0, 0);
        add("o_b0",     0, 1, 1, 0, 0, 4'b1101, 1, 1, 0);
        add("o_b1",     0, 1, 0, 1, 0, 4'b1101, 1, 1, 0);
        add("o_b2",     0, 1, 0, 1, 0, 4'b1101, 1, 1, 0);
        add("o_b3",     0, 1, 0, 0, 0, 4'b1101, 1, 0, 1);
        add("o_hs",     0, 0, 0, 0, 1, 4'b1101, 0, 0, 1);
        add("o_stick",  0, 0, 0, 0, 0, 4'b1101, 0, 0, 1);
        // reset mid-word (with a competing frame bit), then 0,0,1,1
        add("m_b0",     0, 1, 1, 1, 1, 4'b1101, 0, 1, 1);
        add("m_b1",     0, 1, 0, 0, 1, 4'b1101, 0, 1, 1);
        add("m_b2",     0, 1, 0, 1, 1, 4'b1101, 0, 1, 1);
        add("m_rst",    1, 1, 1, 1, 1, 4'b0000, 0, 0, 0);
        add("m_n0",     0, 1, 1, 0, 1, 4'b0000, 0, 1, 0);
        add("m_n1",     0, 1, 0, 0, 1, 4'b0000, 0, 1, 0);
        add("m_n2",     0, 1, 0, 1, 1, 4'b0000, 0, 1, 0);
        add("m_n3",     0, 1, 0, 1, 1, 4'b1100, 1, 0, 0);
        add("m_hs",     0, 0, 0, 0, 1, 4'b1100, 0, 0, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].sin_en, vecs[i].frame, vecs[i].sin, vecs[i].rdy);
            check_all(vecs[i].name, vecs[i].ey, vecs[i].ev, vecs[i].eb, vecs[i].eo);
        end

        // Word completing on the same cycle as a handshake replaces y, no overrun.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        check_all("hs_first", 4'b1111, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        check_all("hs_same", 4'b0010, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check_all("hs_drain", 4'b0010, 0, 0, 0);

        // Loopback from an LSB-first PISO loaded with x; bit k lands in y[W-k].
        x = 4'b1010;
        for (int k = 0; k < W; k++) ex[W - k] = x[k];
        for (int k = 0; k < W; k++) cycle(0, 1, (k == 0), x[k], 1);
        check_all("loopback", ex, 1, 0, 0);
        chk("loopback.word", 32'(y), 32'(4'b1010));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_reg_sipo.md
SHIFT_REG_SIPO -- requirements
Module: shift_reg_sipo

Interface
REQ-001 The block SHALL have exactly one parameter, listed below.
REQ-002 WIDTH, 4, word length in bits; legal range 2..16.
REQ-003 The block SHALL have exactly the ports listed below, clock and reset first.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 sin  input  1  serial data bit.
REQ-007 sin_en  input  1  sin is valid this cycle.
REQ-008 frame  input  1  marks the current sin bit as bit 0 of a word; meaningful only when sin_en=1.
REQ-009 y  output  [1:WIDTH]  assembled parallel word, registered.
REQ-010 y_valid  output  1  y holds an unconsumed word.
REQ-011 y_ready  input  1  consumer accepts y when y_valid=1.
REQ-012 busy  output  1  a word is partially received.
REQ-013 overrun  output  1  sticky flag; a completed word was dropped.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-015 Bit order SHALL be: received bit k (k=0..WIDTH-1) lands in y[WIDTH-k], so the first bit goes to y[WIDTH] and the last to y[1].
REQ-016 In IDLE, sin_en=1 and frame=1 SHALL capture bit 0, set the bit count to 1 and move to SHIFT.
REQ-017 In IDLE, sin_en=1 with frame=0 SHALL be ignored: no state change.
REQ-018 In SHIFT, sin_en=0 SHALL hold all state; gaps of any length are legal.
REQ-019 In SHIFT, sin_en=1 and frame=0 SHALL capture the next bit and increment the count.
REQ-020 In SHIFT, sin_en=1 and frame=1 SHALL discard the partial word, capture sin as the new bit 0 and set the count to 1, without setting overrun.
REQ-021 When bit WIDTH-1 is captured, the FSM SHALL return to IDLE, and the word SHALL be offered to the output stage on the same edge.
REQ-022 Output latency: y and y_valid SHALL update on the edge that samples the last bit, i.e. they are visible the cycle after the last bit is presented.
REQ-023 A handshake completes on a cycle where y_valid=1 and y_ready=1; y_valid SHALL then clear on the next edge unless a new word is loaded on that edge.
REQ-024 When y_valid=1, y SHALL remain stable until the handshake completes.
REQ-025 A word completing while y_valid=1 and y_ready=0 SHALL be dropped: y stays unchanged and overrun is set.
REQ-026 A word completing on the same cycle as a handshake SHALL be loaded into y, y_valid stays 1, and overrun is not set.
REQ-027 overrun SHALL stay at 1 until rst.
REQ-028 busy SHALL be 1 exactly when the state is SHIFT.
REQ-029 Back-to-back words SHALL be accepted: a frame bit on the cycle after the last bit of the previous word starts a new word.
REQ-030 The bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.

Reset
REQ-031 When rst=1 is sampled, the block SHALL clear on that clock edge: state=IDLE, count=0, shift register=0, y=0, y_valid=0, busy=0, overrun=0.
REQ-032 rst SHALL take priority over all other inputs.
REQ-033 Assertion of rst mid-word SHALL abandon the partial word, and no y_valid SHALL be produced for it.

Structure
REQ-034 The state encodings (IDLE=0, SHIFT=1) and the counter-width function SHALL live in shared package shift_reg_pkg, alongside the PISO constants.
REQ-035 The block SHALL contain one sub-module, sipo_shift_core: a WIDTH-bit shift register with enable and restart inputs; the FSM, counter and output handshake stay in the top level.
REQ-036 The block SHALL contain no latches and no combinational path from sin to y.

Verification (WIDTH=4)
REQ-037 Scenario: frame+sin_en with bits 1,0,1,1 on four consecutive cycles, y_ready=1 -> next cycle y=4'b1101 (y[1..4]), y_valid=1 for one cycle.
REQ-038 Scenario: same bits with sin_en low for 3 cycles between bits 1 and 2 -> y=4'b1101, busy=1 throughout the gap.
REQ-039 Scenario: after 2 bits, frame reasserted with bits 0,0,0,1 -> y=4'b1000, overrun=0.
REQ-040 Scenario: two back-to-back words 1101 then 0110 with y_ready=0 -> y=4'b1101 held, overrun=1 after the second word; raising y_ready clears y_valid.
REQ-041 Scenario: rst asserted after 3 bits, then a full word 0011 -> no y_valid before the new word, then y=4'b1100.
REQ-042 Scenario: loopback from shift_reg_piso loaded with x=4'b1010 -> y=4'b1010.
